// File: rtl/rx_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// rx_boxcar_decimator: integrate-and-dump I/Q decimator with an AXI-stream
// output FIFO for one RX channel.                          Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_boxcar_decimator #(
  parameter int FIFO_DEPTH   = 16,
  parameter int DEFAULT_RATE = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   rate_axis_tdata_i,
  input  logic                          rate_axis_tvalid_i,
  input  logic [31:0]                   rx_iq_axis_tdata_i,
  input  logic                          rx_iq_axis_tvalid_i,
  input  logic                          axis_tready_i,
  output logic [63:0]                   axis_tdata_o,
  output logic                          axis_tvalid_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     RATE_RST  = 16'(DEFAULT_RATE);
  localparam logic [AW:0]     FILL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     FILL_ONE  = (AW+1)'(1);

  logic [15:0]        rate;
  logic [15:0]        cnt;
  logic signed [31:0] acc_i;
  logic signed [31:0] acc_q;
  logic [63:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        fill;
  logic [63:0]        head;
  logic               head_valid;
  logic               overflow;

  logic [15:0]        d_new;
  logic [15:0]        d_cur;
  logic [15:0]        d_eff;
  logic [15:0]        base_cnt;
  logic signed [31:0] base_i;
  logic signed [31:0] base_q;
  logic signed [31:0] samp_i;
  logic signed [31:0] samp_q;
  logic signed [31:0] sum_i;
  logic signed [31:0] sum_q;
  logic [63:0]        push_word;
  logic               dump;
  logic               pop;
  logic               full;
  logic               push;
  logic               drop;
  logic [AW-1:0]      rd_next;
  logic [AW:0]        fill_next;

  // A rate write restarts the window, so the same-cycle sample sees a zero base.
  always_comb begin
    d_new     = (rate_axis_tdata_i == 16'd0) ? 16'd1 : rate_axis_tdata_i;
    d_cur     = (rate == 16'd0) ? 16'd1 : rate;
    d_eff     = rate_axis_tvalid_i ? d_new : d_cur;
    base_cnt  = rate_axis_tvalid_i ? 16'd0 : cnt;
    base_i    = rate_axis_tvalid_i ? 32'sd0 : acc_i;
    base_q    = rate_axis_tvalid_i ? 32'sd0 : acc_q;
    samp_i    = 32'(signed'(rx_iq_axis_tdata_i[15:0]));
    samp_q    = 32'(signed'(rx_iq_axis_tdata_i[31:16]));
    sum_i     = base_i + samp_i;
    sum_q     = base_q + samp_q;
    push_word = {sum_q, sum_i};
    dump      = rx_iq_axis_tvalid_i && (base_cnt == (d_eff - 16'd1));
    pop       = head_valid && axis_tready_i;
    full      = (fill == FILL_FULL);
    push      = dump && (!full || pop);
    drop      = dump && full && !pop;
    rd_next   = rd_ptr + 1'b1;
    fill_next = fill;
    if (push && !pop) fill_next = fill + FILL_ONE;
    else if (pop && !push) fill_next = fill - FILL_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate  <= RATE_RST;
      cnt   <= 16'd0;
      acc_i <= 32'sd0;
      acc_q <= 32'sd0;
    end else begin
      if (rate_axis_tvalid_i) rate <= rate_axis_tdata_i;
      if (rx_iq_axis_tvalid_i) begin
        if (dump) begin
          cnt   <= 16'd0;
          acc_i <= 32'sd0;
          acc_q <= 32'sd0;
        end else begin
          cnt   <= base_cnt + 16'd1;
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end else if (rate_axis_tvalid_i) begin
        cnt   <= 16'd0;
        acc_i <= 32'sd0;
        acc_q <= 32'sd0;
      end
    end
  end

  // A drop in the same cycle as a rate write belongs to the new window, so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (rate_axis_tvalid_i) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // The head register mirrors mem[rd_ptr] so the output data comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      head       <= 64'd0;
      head_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      fill       <= fill_next;
      head_valid <= (fill_next != '0);
      if (pop) begin
        if (fill > FILL_ONE) head <= mem[rd_next];
        else if (push)       head <= push_word;
      end else if ((fill == '0) && push) begin
        head <= push_word;
      end
    end
  end

  assign axis_tdata_o  = head;
  assign axis_tvalid_o = head_valid;
  assign overflow_o    = overflow;
  assign fill_o        = fill;

endmodule

`default_nettype wire
